fpu_cvt_sched: RTL and testbench

Scheduler and arbiter for the shared integer-to-FP64 convert unit in the FPU. It collects conversion requests from NREQ issue sources using round-robin arbitration. It drives the converter's enable, is32 and src inputs and holds them stable for a fixed settle latency. It then captures the converter output and returns it, tagged, to the requester over a valid/ready response channel. At most one conversion is in flight at a time.

---
 rtl/fpu_cvt_pkg.sv | 17 +
 rtl/fpu_rr_arb.sv | 35 +++
 rtl/fpu_cvt_sched.sv | 151 +++++++++++++++
 tb/tb_fpu_cvt_sched.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_cvt_pkg.sv
// Shared types and constants for the integer-to-FP64 convert scheduler.
package fpu_cvt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } cvt_state_e;

  localparam logic [63:0] FP64_POS_ZERO = 64'h0;

  // Index width for n requesters, never narrower than one bit.
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpu_rr_arb.sv
// Combinational round-robin picker: the first valid slot strictly after i_ptr wins,
// wrapping; the pointer register itself lives in the parent.
module fpu_rr_arb
  import fpu_cvt_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idw(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] w_cand;
  logic          w_hit;
  logic          w_found;

  // Walk outward from the slot after the pointer; only the first hit latches.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_cand  = '0;
    w_hit   = 1'b0;
    w_found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      w_cand        = IW'((int'(i_ptr) + k) % N);
      w_hit         = i_req[w_cand] & ~w_found;
      o_gnt[w_cand] = o_gnt[w_cand] | w_hit;
      o_idx         = w_hit ? w_cand : o_idx;
      w_found       = w_found | w_hit;
    end
  end

endmodule

// File: rtl/fpu_cvt_sched.sv
// Round-robin scheduler for the shared int-to-FP64 converter, one operation in flight.
// Optional zero-source bypass when FPU_CVT_ZERO_BYPASS_EN is defined.
module fpu_cvt_sched
  import fpu_cvt_pkg::*;
#(
  parameter  int NREQ    = 2,
  parameter  int CVT_LAT = 2,
  parameter  int TAGW    = 4,
  localparam int IDW     = idw(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_is32,
  input  logic [64*NREQ-1:0]   req_src,
  input  logic [TAGW*NREQ-1:0] req_tag,
  output logic                 cvt_enable,
  output logic                 cvt_is32,
  output logic [63:0]          cvt_src,
  input  logic [63:0]          cvt_dst,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [TAGW-1:0]      rsp_tag,
  output logic [63:0]          rsp_data,
  input  logic                 flush,
  output logic                 busy
);

  localparam int CNTW = $clog2(CVT_LAT + 1);

  cvt_state_e      r_state;
  cvt_state_e      w_state_nxt;
  logic [IDW-1:0]  r_ptr;
  logic [CNTW-1:0] r_cnt;
  logic [63:0]     r_src;
  logic            r_is32;
  logic [TAGW-1:0] r_tag;
  logic [IDW-1:0]  r_id;
  logic [63:0]     r_rsp_data;

  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_gidx;
  logic [63:0]     w_sel_src;
  logic            w_sel_is32;
  logic [TAGW-1:0] w_sel_tag;
  logic            w_open;
  logic            w_accept;
  logic            w_bypass;
  logic            w_last;

  fpu_rr_arb #(.N(NREQ)) u_arb (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gidx)
  );

  assign w_sel_src  = req_src[int'(w_gidx)*64 +: 64];
  assign w_sel_is32 = req_is32[w_gidx];
  assign w_sel_tag  = req_tag[int'(w_gidx)*TAGW +: TAGW];

  // Grants are only offered while idle, not flushing and out of reset.
  assign w_open    = (r_state == IDLE) & ~flush & rst_n;
  assign req_ready = w_open ? w_gnt : {NREQ{1'b0}};
  assign w_accept  = w_open & (|(req_valid & w_gnt));
  assign w_last    = (r_cnt == CNTW'(1));

`ifdef FPU_CVT_ZERO_BYPASS_EN
  assign w_bypass = w_sel_is32 ? (w_sel_src[31:0] == 32'h0) : (w_sel_src == 64'h0);
`else
  assign w_bypass = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush always returns to IDLE without a response.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_accept ? (w_bypass ? RESP : WAIT) : IDLE;
      WAIT:    w_state_nxt = flush ? IDLE : (w_last ? RESP : WAIT);
      RESP:    w_state_nxt = (flush | rsp_ready) ? IDLE : RESP;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand latch, RR pointer, settle counter and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= IDW'(NREQ - 1);
      r_cnt      <= '0;
      r_src      <= 64'h0;
      r_is32     <= 1'b0;
      r_tag      <= '0;
      r_id       <= '0;
      r_rsp_data <= 64'h0;
    end else if (w_accept) begin
      r_ptr  <= w_gidx;
      r_id   <= w_gidx;
      r_cnt  <= CNTW'(CVT_LAT);
      r_src  <= w_sel_src;
      r_is32 <= w_sel_is32;
      r_tag  <= w_sel_tag;
      if (w_bypass) begin
        r_rsp_data <= FP64_POS_ZERO;
      end
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt - CNTW'(1);
      if (w_last && !flush) begin
        r_rsp_data <= cvt_dst;
      end
    end
  end

  // Output decode from the registered state.
  always_comb begin
    cvt_enable = 1'b0;
    cvt_is32   = 1'b0;
    cvt_src    = 64'h0;
    rsp_valid  = 1'b0;
    rsp_id     = '0;
    rsp_tag    = '0;
    rsp_data   = 64'h0;
    busy       = 1'b1;
    case (r_state)
      IDLE: busy = 1'b0;
      WAIT: begin
        cvt_enable = 1'b1;
        cvt_is32   = r_is32;
        cvt_src    = r_src;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = r_id;
        rsp_tag   = r_tag;
        rsp_data  = r_rsp_data;
      end
      default: busy = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fpu_cvt_sched.sv
// Self-checking bench for fpu_cvt_sched: cycle-exact transactions against a
// round-robin / converter-stub reference model, plus randomized traffic.
module tb_fpu_cvt_sched;

  localparam int NREQ    = 2;
  localparam int CVT_LAT = 2;
  localparam int TAGW    = 4;
  localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef FPU_CVT_ZERO_BYPASS_EN
  localparam bit BYP_EN = 1'b1;
`else
  localparam bit BYP_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_is32;
  logic [64*NREQ-1:0]   req_src;
  logic [TAGW*NREQ-1:0] req_tag;
  logic                 cvt_enable;
  logic                 cvt_is32;
  logic [63:0]          cvt_src;
  logic [63:0]          cvt_dst;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [TAGW-1:0]      rsp_tag;
  logic [63:0]          rsp_data;
  logic                 flush;
  logic                 busy;

  logic [63:0]     src_a  [NREQ];
  logic            is32_a [NREQ];
  logic [TAGW-1:0] tag_a  [NREQ];

  int n_cmp = 0;
  int n_bad = 0;
  int m_ptr = NREQ - 1;

  always #5 clk = ~clk;

  // Converter stub.
  assign cvt_dst = cvt_src ^ 64'hA5;

  always_comb begin
    req_src  = '0;
    req_tag  = '0;
    req_is32 = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_src[64*i +: 64]     = src_a[i];
      req_tag[TAGW*i +: TAGW] = tag_a[i];
      req_is32[i]             = is32_a[i];
    end
  end

  fpu_cvt_sched #(.NREQ(NREQ), .CVT_LAT(CVT_LAT), .TAGW(TAGW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_is32   (req_is32),
    .req_src    (req_src),
    .req_tag    (req_tag),
    .cvt_enable (cvt_enable),
    .cvt_is32   (cvt_is32),
    .cvt_src    (cvt_src),
    .cvt_dst    (cvt_dst),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_tag    (rsp_tag),
    .rsp_data   (rsp_data),
    .flush      (flush),
    .busy       (busy)
  );

  // Reference arbitration: first valid requester strictly after the pointer.
  function automatic int model_grant(input logic [NREQ-1:0] m);
    for (int k = 1; k <= NREQ; k++) begin
      if (m[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One transaction starting in an IDLE cycle; flush_at 1..CVT_LAT flushes
  // in that WAIT cycle, CVT_LAT+1 flushes in the first RESP cycle.
  task automatic do_txn(input logic [NREQ-1:0] mask, input int delay, input int flush_at);
    int              g;
    logic [NREQ-1:0] xr;
    logic [63:0]     xs;
    logic [63:0]     xd;
    logic            x32;
    logic            byp;
    logic [TAGW-1:0] xt;
    req_valid = mask;
    rsp_ready = 1'b0;
    flush     = 1'b0;
    #1;
    g     = model_grant(mask);
    xr    = '0;
    xr[g] = 1'b1;
    xs    = src_a[g];
    x32   = is32_a[g];
    xt    = tag_a[g];
    byp   = BYP_EN && (x32 ? (xs[31:0] == 32'h0) : (xs == 64'h0));
    xd    = byp ? 64'h0 : (xs ^ 64'hA5);
    n_cmp++; if (req_ready !== xr) begin n_bad++; $display("FAIL grant: req_ready=%b expected %b", req_ready, xr); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: busy=%b expected 0", busy); end
    n_cmp++; if (cvt_enable !== 1'b0) begin n_bad++; $display("FAIL idle_cvt_en: cvt_enable=%b expected 0", cvt_enable); end
    tick;
    m_ptr = g;
    if (!byp) begin
      for (int c = 1; c <= CVT_LAT; c++) begin
        if (flush_at == c) flush = 1'b1;
        #1;
        n_cmp++; if (cvt_enable !== 1'b1) begin n_bad++; $display("FAIL wait_cvt_en: cvt_enable=%b expected 1 (cycle %0d)", cvt_enable, c); end
        n_cmp++; if (cvt_src !== xs) begin n_bad++; $display("FAIL wait_cvt_src: cvt_src=%h expected %h", cvt_src, xs); end
        n_cmp++; if (cvt_is32 !== x32) begin n_bad++; $display("FAIL wait_cvt_is32: cvt_is32=%b expected %b", cvt_is32, x32); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL wait_rsp_valid: rsp_valid=%b expected 0", rsp_valid); end
        n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL wait_req_ready: req_ready=%b expected 0", req_ready); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wait_busy: busy=%b expected 1", busy); end
        tick;
        if (flush_at == c) begin
          flush = 1'b0;
          #1;
          n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_wait_busy: busy=%b expected 0", busy); end
          n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL flush_wait_rsp: rsp_valid=%b expected 0", rsp_valid); end
          return;
        end
      end
    end
    if (flush_at == CVT_LAT + 1) flush = 1'b1;
    #1;
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rsp_valid: rsp_valid=%b expected 1", rsp_valid); end
    n_cmp++; if (rsp_data !== xd) begin n_bad++; $display("FAIL rsp_data: rsp_data=%h expected %h", rsp_data, xd); end
    n_cmp++; if (rsp_id !== IDW'(g)) begin n_bad++; $display("FAIL rsp_id: rsp_id=%0d expected %0d", rsp_id, g); end
    n_cmp++; if (rsp_tag !== xt) begin n_bad++; $display("FAIL rsp_tag: rsp_tag=%h expected %h", rsp_tag, xt); end
    n_cmp++; if (cvt_enable !== 1'b0) begin n_bad++; $display("FAIL resp_cvt_en: cvt_enable=%b expected 0", cvt_enable); end
    n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL resp_req_ready: req_ready=%b expected 0", req_ready); end
    if (flush_at == CVT_LAT + 1) begin
      tick;
      flush = 1'b0;
      #1;
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL flush_resp_valid: rsp_valid=%b expected 0", rsp_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_resp_busy: busy=%b expected 0", busy); end
      return;
    end
    for (int d = 0; d < delay; d++) begin
      tick;
      #1;
      n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid: rsp_valid=%b expected 1 (cycle %0d)", rsp_valid, d); end
      n_cmp++; if (rsp_data !== xd) begin n_bad++; $display("FAIL hold_data: rsp_data=%h expected %h", rsp_data, xd); end
      n_cmp++; if (rsp_tag !== xt) begin n_bad++; $display("FAIL hold_tag: rsp_tag=%h expected %h", rsp_tag, xt); end
      n_cmp++; if (rsp_id !== IDW'(g)) begin n_bad++; $display("FAIL hold_id: rsp_id=%0d expected %0d", rsp_id, g); end
      n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL hold_req_ready: req_ready=%b expected 0", req_ready); end
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL done_rsp_valid: rsp_valid=%b expected 0", rsp_valid); end
  endtask

  task automatic check_all_zero(input string nm);
    n_cmp++;
    if ({req_ready, cvt_enable, cvt_is32, cvt_src, rsp_valid, rsp_id, rsp_tag, rsp_data, busy} !== '0) begin
      n_bad++;
      $display("FAIL %s: req_ready=%b cvt_en=%b cvt_src=%h rsp_valid=%b id=%0d tag=%h data=%h busy=%b expected all 0",
               nm, req_ready, cvt_enable, cvt_src, rsp_valid, rsp_id, rsp_tag, rsp_data, busy);
    end
  endtask

  task automatic test_reset;
    req_valid = '1;
    #2;
    check_all_zero("reset_outputs");
    tick;
    rst_n     = 1'b1;
    req_valid = '0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_release_busy: busy=%b expected 0", busy); end
  endtask

  task automatic test_single;
    src_a[0] = 64'd5; is32_a[0] = 1'b0; tag_a[0] = 4'd3;
    do_txn(NREQ'(1), 0, 0);
    req_valid = '0;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < NREQ; i++) begin
      src_a[i] = {$urandom, $urandom}; is32_a[i] = 1'b0; tag_a[i] = TAGW'(i + 7);
    end
    for (int n = 0; n < 4; n++) do_txn('1, 0, 0);
  endtask

  task automatic test_hold;
    do_txn('1, 5, 0);
  endtask

  task automatic test_flush;
    do_txn('1, 0, 2);
    do_txn('1, 0, 0);
    do_txn('1, 0, CVT_LAT + 1);
    do_txn('1, 0, 0);
  endtask

  task automatic test_flush_idle;
    req_valid = '1;
    flush     = 1'b1;
    #1;
    n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL flush_idle_ready: req_ready=%b expected 0", req_ready); end
    tick;
    flush = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_idle_busy: busy=%b expected 0", busy); end
    req_valid = '0;
  endtask

  task automatic test_zero_src;
    src_a[0] = 64'h0;                   is32_a[0] = 1'b0; tag_a[0] = 4'h5;
    src_a[1] = 64'hFFFF_FFFF_0000_0000; is32_a[1] = 1'b1; tag_a[1] = 4'hA;
    do_txn(NREQ'(1), 0, 0);
    do_txn(NREQ'(2), 1, 0);
    req_valid = '0;
  endtask

  task automatic test_reset_mid;
    src_a[0] = 64'h1234; is32_a[0] = 1'b0; tag_a[0] = 4'h6;
    req_valid = NREQ'(1);
    #1;
    tick;
    req_valid = '1;
    repeat (CVT_LAT) tick;
    n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL pre_reset_valid: rsp_valid=%b expected 1", rsp_valid); end
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_outputs");
    tick;
    rst_n = 1'b1;
    m_ptr = NREQ - 1;
    do_txn('1, 0, 0);
  endtask

  task automatic test_random;
    logic [NREQ-1:0] mask;
    int              fa;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        src_a[i]  = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) src_a[i][31:0] = 32'h0;
        is32_a[i] = 1'($urandom_range(0, 1));
        tag_a[i]  = TAGW'($urandom);
      end
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      fa   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, CVT_LAT + 1)) : 0;
      do_txn(mask, int'($urandom_range(0, 3)), fa);
    end
    req_valid = '0;
  endtask

  initial begin
    req_valid = '0;
    rsp_ready = 1'b0;
    flush     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      src_a[i] = 64'h0; is32_a[i] = 1'b0; tag_a[i] = '0;
    end
    test_reset;
    test_single;
    test_back_to_back;
    test_hold;
    test_flush;
    test_flush_idle;
    test_zero_src;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
